// File: rtl/mmr_reg_bank_if.sv
// ============================================================================
// Module      : axi3_if
// Description : AXI3 bus bundle (AW, W, B, AR, R) for the memory-mapped
//               register bank. The master modport is used by whoever issues
//               transactions; the slave modport is used by the register bank.
//   Parameters: DATA_W - data width, ID_W - transaction ID width.
//   Signals   : full AXI3 channel set incl. id, len[3:0], size, burst,
//               wid, wstrb, last. Address is a fixed 32-bit byte address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi3_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
);
    // Write address channel
    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    // Write data channel
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // Write response channel
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // Read address channel
    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    // Read data channel
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

`default_nettype wire

// File: rtl/mmr_reg_bank.sv
// ============================================================================
// Module      : mmr_reg_bank
// Description : AXI3 slave register bank. Word index addr[7:2] selects
//               RW control registers at 0..CTRL_COUNT-1 and RO status
//               registers at 32..32+STAT_COUNT-1; everything else is
//               unmapped and answers SLVERR. Independent write and read
//               state machines run concurrently.
//   clk      in   block clock
//   rst      in   synchronous active-high reset
//   mmr      slave AXI3 bus (axi3_if.slave)
//   ctrl     out  control register contents
//   ctrl_wr  out  one-cycle pulse per control register written
//   stat     in   status values, sampled when a read beat is registered
//   stat_rd  out  one-cycle pulse per status register read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_reg_bank #(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 12,
    parameter int CTRL_COUNT = 8,
    parameter int STAT_COUNT = 8
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    axi3_if.slave                                    mmr,
    output logic [CTRL_COUNT-1:0][DATA_W-1:0]        ctrl,
    output logic [CTRL_COUNT-1:0]                    ctrl_wr,
    input  wire logic [STAT_COUNT-1:0][DATA_W-1:0]   stat,
    output logic [STAT_COUNT-1:0]                    stat_rd
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;
    localparam logic [5:0] C_STAT_BASE   = 6'd32;

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    logic [1:0]                       wr_state_q, wr_state_d;
    logic [5:0]                       wr_idx_q,   wr_idx_d;
    logic                             wr_fixed_q, wr_fixed_d;
    logic [ID_W-1:0]                  wr_id_q,    wr_id_d;
    logic                             wr_err_q,   wr_err_d;   // sticky SLVERR for the burst
    logic [CTRL_COUNT-1:0][DATA_W-1:0] ctrl_q,    ctrl_d;
    logic [CTRL_COUNT-1:0]            ctrl_wr_q,  ctrl_wr_d;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    logic [0:0]                       rd_state_q, rd_state_d;
    logic [5:0]                       rd_idx_q,   rd_idx_d;
    logic                             rd_fixed_q, rd_fixed_d;
    logic [ID_W-1:0]                  rd_id_q,    rd_id_d;
    logic [3:0]                       rd_len_q,   rd_len_d;
    logic [3:0]                       rd_beat_q,  rd_beat_d;
    logic [DATA_W-1:0]                rd_data_q,  rd_data_d;
    logic [1:0]                       rd_resp_q,  rd_resp_d;
    logic                             rd_last_q,  rd_last_d;
    logic [STAT_COUNT-1:0]            stat_rd_q,  stat_rd_d;

    logic                             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs;
    logic                             w_wr_hit;
    logic [5:0]                       w_look_idx;
    logic [DATA_W-1:0]                w_look_data;
    logic [1:0]                       w_look_resp;
    logic [STAT_COUNT-1:0]            w_look_stat;
    logic                             w_unused;

    // ------------------------------------------------------------------
    // Bus outputs. Ready/valid are gated by rst so nothing is offered
    // while reset is held, even before the first clock edge.
    // ------------------------------------------------------------------
    assign mmr.awready = (wr_state_q == W_IDLE) && !rst;
    assign mmr.wready  = (wr_state_q == W_DATA) && !rst;
    assign mmr.bvalid  = (wr_state_q == W_RESP) && !rst;
    assign mmr.bid     = wr_id_q;
    assign mmr.bresp   = wr_err_q ? C_RESP_SLVERR : C_RESP_OKAY;

    assign mmr.arready = (rd_state_q == R_IDLE) && !rst;
    assign mmr.rvalid  = (rd_state_q == R_DATA) && !rst;
    assign mmr.rid     = rd_id_q;
    assign mmr.rdata   = rd_data_q;
    assign mmr.rresp   = rd_resp_q;
    assign mmr.rlast   = rd_last_q;

    assign ctrl    = ctrl_q;
    assign ctrl_wr = ctrl_wr_q;
    assign stat_rd = stat_rd_q;

    assign w_aw_hs = mmr.awvalid && mmr.awready;
    assign w_w_hs  = mmr.wvalid  && mmr.wready;
    assign w_b_hs  = mmr.bvalid  && mmr.bready;
    assign w_ar_hs = mmr.arvalid && mmr.arready;

    // Address bits outside the word index, lengths of write bursts (wlast
    // terminates), sizes and wid are intentionally ignored.
    assign w_unused = ^{mmr.awaddr[31:8], mmr.awaddr[1:0], mmr.awlen, mmr.awsize,
                        mmr.wid, mmr.araddr[31:8], mmr.araddr[1:0], mmr.arsize};

    // ------------------------------------------------------------------
    // Write state machine
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_fixed_d = wr_fixed_q;
        wr_id_d    = wr_id_q;
        wr_err_d   = wr_err_q;
        ctrl_d     = ctrl_q;
        ctrl_wr_d  = '0;
        w_wr_hit   = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    wr_id_d    = mmr.awid;
                    wr_idx_d   = mmr.awaddr[7:2];
                    wr_fixed_d = (mmr.awburst == C_BURST_FIXED);
                    wr_err_d   = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    for (int i = 0; i < CTRL_COUNT; i++) begin
                        if (wr_idx_q == 6'(i)) begin
                            w_wr_hit     = 1'b1;
                            ctrl_wr_d[i] = 1'b1;
                            for (int b = 0; b < STRB_W; b++) begin
                                if (mmr.wstrb[b]) begin
                                    ctrl_d[i][8*b +: 8] = mmr.wdata[8*b +: 8];
                                end
                            end
                        end
                    end
                    // Status and unmapped beats are dropped but poison the burst.
                    if (!w_wr_hit) begin
                        wr_err_d = 1'b1;
                    end
                    // WRAP is handled as INCR; 6-bit index wraps 63 -> 0.
                    if (!wr_fixed_q) begin
                        wr_idx_d = wr_idx_q + 6'd1;
                    end
                    if (mmr.wlast) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    wr_err_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read lookup: index of the beat about to be registered. In R_IDLE it
    // comes straight from araddr, in R_DATA it is the next burst index.
    // Reads use ctrl_q, so a same-cycle write is not yet visible.
    // ------------------------------------------------------------------
    assign w_look_idx = (rd_state_q == R_IDLE) ? mmr.araddr[7:2]
                      : (rd_fixed_q ? rd_idx_q : rd_idx_q + 6'd1);

    always_comb begin
        w_look_data = '0;
        w_look_resp = C_RESP_SLVERR;
        w_look_stat = '0;
        for (int i = 0; i < CTRL_COUNT; i++) begin
            if (w_look_idx == 6'(i)) begin
                w_look_data = ctrl_q[i];
                w_look_resp = C_RESP_OKAY;
            end
        end
        for (int j = 0; j < STAT_COUNT; j++) begin
            if (w_look_idx == (C_STAT_BASE + 6'(j))) begin
                w_look_data    = stat[j];
                w_look_resp    = C_RESP_OKAY;
                w_look_stat[j] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read state machine
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_fixed_d = rd_fixed_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        rd_last_d  = rd_last_q;
        stat_rd_d  = '0;

        case (rd_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rd_id_d    = mmr.arid;
                    rd_len_d   = mmr.arlen;
                    rd_fixed_d = (mmr.arburst == C_BURST_FIXED);
                    rd_idx_d   = w_look_idx;
                    rd_beat_d  = 4'd0;
                    rd_data_d  = w_look_data;
                    rd_resp_d  = w_look_resp;
                    stat_rd_d  = w_look_stat;
                    rd_last_d  = (mmr.arlen == 4'd0);
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // Nothing changes until rready; this holds the beat stable.
                if (mmr.rready) begin
                    if (rd_last_q) begin
                        rd_last_d  = 1'b0;
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_idx_d  = w_look_idx;
                        rd_beat_d = rd_beat_q + 4'd1;
                        rd_data_d = w_look_data;
                        rd_resp_d = w_look_resp;
                        stat_rd_d = w_look_stat;
                        rd_last_d = ((rd_beat_q + 4'd1) == rd_len_q);
                    end
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_fixed_q <= 1'b0;
            wr_id_q    <= '0;
            wr_err_q   <= 1'b0;
            ctrl_q     <= '0;
            ctrl_wr_q  <= '0;
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_fixed_q <= 1'b0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_data_q  <= '0;
            rd_resp_q  <= C_RESP_OKAY;
            rd_last_q  <= 1'b0;
            stat_rd_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_fixed_q <= wr_fixed_d;
            wr_id_q    <= wr_id_d;
            wr_err_q   <= wr_err_d;
            ctrl_q     <= ctrl_d;
            ctrl_wr_q  <= ctrl_wr_d;
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_fixed_q <= rd_fixed_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
            rd_last_q  <= rd_last_d;
            stat_rd_q  <= stat_rd_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmr_reg_bank.sv
// ============================================================================
// Module      : tb_mmr_reg_bank
// Description : Self-checking bench for mmr_reg_bank. A register-array model
//               of the bank predicts write responses, control contents and
//               every read beat; directed cases are followed by random ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmr_reg_bank;

    localparam int DATA_W = 32;
    localparam int ID_W   = 12;
    localparam int CC     = 8;
    localparam int SC     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi3_if #(.DATA_W(DATA_W), .ID_W(ID_W)) mmr ();

    logic [CC-1:0][DATA_W-1:0] ctrl;
    logic [CC-1:0]             ctrl_wr;
    logic [SC-1:0][DATA_W-1:0] stat;
    logic [SC-1:0]             stat_rd;

    mmr_reg_bank #(
        .DATA_W(DATA_W), .ID_W(ID_W), .CTRL_COUNT(CC), .STAT_COUNT(SC)
    ) dut (
        .clk(clk), .rst(rst), .mmr(mmr),
        .ctrl(ctrl), .ctrl_wr(ctrl_wr), .stat(stat), .stat_rd(stat_rd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of control register values.
    logic [DATA_W-1:0] m_ctrl [CC];
    logic [DATA_W-1:0] wdat [16];
    logic [3:0]        wstb [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input int idx);
        if (idx < CC) return m_ctrl[idx];
        if (idx >= 32 && idx < 32 + SC) return stat[idx-32];
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_rresp(input int idx);
        if (idx < CC || (idx >= 32 && idx < 32 + SC)) return 2'b00;
        return 2'b10;
    endfunction

    task automatic chk_all_ctrl(input string tag);
        for (int i = 0; i < CC; i++) chk($sformatf("%s_ctrl%0d", tag, i), ctrl[i], m_ctrl[i]);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] burst,
                            input int n, input logic [ID_W-1:0] id);
        int idx, cnt;
        bit err;
        idx = int'(addr[7:2]);
        err = 1'b0;
        @(negedge clk);
        mmr.awvalid = 1'b1; mmr.awid = id; mmr.awaddr = addr;
        mmr.awlen = 4'(n - 1); mmr.awsize = 3'd2; mmr.awburst = burst;
        cnt = 0;
        while (mmr.awready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("aw_accept", 32'(mmr.awready), 32'd1);
        @(negedge clk);
        mmr.awvalid = 1'b0;
        chk("awready_busy", 32'(mmr.awready), 32'd0);
        for (int k = 0; k < n; k++) begin
            mmr.wvalid = 1'b1; mmr.wdata = wdat[k]; mmr.wstrb = wstb[k];
            mmr.wlast = (k == n - 1); mmr.wid = ~id;
            cnt = 0;
            while (mmr.wready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
            chk("w_accept", 32'(mmr.wready), 32'd1);
            if (idx < CC) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[k][b]) m_ctrl[idx][8*b +: 8] = wdat[k][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            @(negedge clk);
            mmr.wvalid = 1'b0; mmr.wlast = 1'b0;
            chk("ctrl_wr", 32'(ctrl_wr), (idx < CC) ? (32'd1 << idx) : 32'd0);
            if (idx < CC) chk("ctrl_beat", ctrl[idx], m_ctrl[idx]);
            if (burst != 2'b00) idx = (idx + 1) % 64;
        end
        chk("bvalid", 32'(mmr.bvalid), 32'd1);
        chk("bid", 32'(mmr.bid), 32'(id));
        chk("bresp", 32'(mmr.bresp), err ? 32'd2 : 32'd0);
        mmr.bready = 1'b1;
        @(negedge clk);
        mmr.bready = 1'b0;
        chk("bvalid_drop", 32'(mmr.bvalid), 32'd0);
        chk("awready_back", 32'(mmr.awready), 32'd1);
        chk_all_ctrl("wr");
    endtask

    // mode: 0 = rready always high, 1 = pattern 1,0,0,1, 2 = random
    task automatic do_read(input logic [31:0] addr, input logic [1:0] burst,
                           input int n, input logic [ID_W-1:0] id, input int mode);
        int idx, cnt, k, pc;
        bit first;
        idx = int'(addr[7:2]);
        @(negedge clk);
        mmr.arvalid = 1'b1; mmr.arid = id; mmr.araddr = addr;
        mmr.arlen = 4'(n - 1); mmr.arsize = 3'd2; mmr.arburst = burst;
        cnt = 0;
        while (mmr.arready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("ar_accept", 32'(mmr.arready), 32'd1);
        @(negedge clk);
        mmr.arvalid = 1'b0;
        k = 0; pc = 0; first = 1'b1; cnt = 0;
        while (k < n && cnt < 200) begin
            chk("rvalid", 32'(mmr.rvalid), 32'd1);
            chk("rdata", mmr.rdata, exp_rdata(idx));
            chk("rresp", 32'(mmr.rresp), 32'(exp_rresp(idx)));
            chk("rid", 32'(mmr.rid), 32'(id));
            chk("rlast", 32'(mmr.rlast), 32'(k == n - 1));
            chk("stat_rd", 32'(stat_rd),
                (first && idx >= 32 && idx < 32 + SC) ? (32'd1 << (idx - 32)) : 32'd0);
            case (mode)
                0:       mmr.rready = 1'b1;
                1:       mmr.rready = (pc % 4 == 0) || (pc % 4 == 3);
                default: mmr.rready = ($urandom_range(0, 3) != 0);
            endcase
            pc++;
            @(negedge clk);
            if (mmr.rready) begin
                k++;
                first = 1'b1;
                if (burst != 2'b00) idx = (idx + 1) % 64;
            end else begin
                first = 1'b0;
            end
            cnt++;
        end
        mmr.rready = 1'b0;
        chk("rvalid_end", 32'(mmr.rvalid), 32'd0);
        chk("arready_back", 32'(mmr.arready), 32'd1);
    endtask

    initial begin
        logic [31:0] old_v;
        int n, sel, idx;

        mmr.awvalid = 0; mmr.awid = 0; mmr.awaddr = 0; mmr.awlen = 0; mmr.awsize = 0; mmr.awburst = 0;
        mmr.wvalid = 0; mmr.wid = 0; mmr.wdata = 0; mmr.wstrb = 0; mmr.wlast = 0; mmr.bready = 0;
        mmr.arvalid = 0; mmr.arid = 0; mmr.araddr = 0; mmr.arlen = 0; mmr.arsize = 0; mmr.arburst = 0;
        mmr.rready = 0;
        for (int k = 0; k < SC; k++) stat[k] = 32'(k + 1);
        for (int i = 0; i < CC; i++) m_ctrl[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_ctrl("rst");
        chk("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        chk("rst_stat_rd", 32'(stat_rd), 32'd0);
        chk("rst_awready", 32'(mmr.awready), 32'd0);
        chk("rst_wready", 32'(mmr.wready), 32'd0);
        chk("rst_bvalid", 32'(mmr.bvalid), 32'd0);
        chk("rst_arready", 32'(mmr.arready), 32'd0);
        chk("rst_rvalid", 32'(mmr.rvalid), 32'd0);
        chk("rst_rlast", 32'(mmr.rlast), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", 32'(mmr.awready), 32'd1);
        chk("post_rst_arready", 32'(mmr.arready), 32'd1);

        // Single full-word write to ctrl[1]
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(32'h04, 2'b01, 1, 12'h5A3);

        // Byte-lane merge on ctrl[0]
        wdat[0] = 32'hAAAAAAAA; wstb[0] = 4'hF;
        do_write(32'h00, 2'b01, 1, 12'h001);
        wdat[0] = 32'h12345678; wstb[0] = 4'h3;
        do_write(32'h00, 2'b01, 1, 12'h002);
        chk("merge_ctrl0", ctrl[0], 32'hAAAA5678);

        // INCR status burst, back-to-back beats
        do_read(32'h80, 2'b01, 4, 12'h0C1, 0);

        // Write to a status register and read of an unmapped index
        wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
        do_write(32'h80, 2'b01, 1, 12'h033);
        do_read(32'h40, 2'b01, 1, 12'h044, 0);

        // Stalled read burst over control registers
        do_read(32'h00, 2'b01, 4, 12'h055, 1);

        // FIXED burst: every beat lands on ctrl[3]
        for (int k = 0; k < 3; k++) begin wdat[k] = $urandom; wstb[k] = 4'(4'h1 << k); end
        do_write(32'h0C, 2'b00, 3, 12'h066);

        // INCR burst from index 63 wraps to index 0
        for (int k = 0; k < 3; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        do_write(32'hFC, 2'b01, 3, 12'h077);
        do_read(32'hFC, 2'b10, 3, 12'h078, 0);

        // Read and write of ctrl[2] in the same cycle: read sees old value
        old_v = m_ctrl[2];
        @(negedge clk);
        mmr.awvalid = 1'b1; mmr.awid = 12'h0A1; mmr.awaddr = 32'h08;
        mmr.awlen = 4'd0; mmr.awburst = 2'b01; mmr.awsize = 3'd2;
        @(negedge clk);
        mmr.awvalid = 1'b0;
        mmr.wvalid = 1'b1; mmr.wdata = ~old_v; mmr.wstrb = 4'hF; mmr.wlast = 1'b1;
        mmr.arvalid = 1'b1; mmr.arid = 12'h0A2; mmr.araddr = 32'h08;
        mmr.arlen = 4'd0; mmr.arburst = 2'b01; mmr.arsize = 3'd2;
        chk("conc_wready", 32'(mmr.wready), 32'd1);
        chk("conc_arready", 32'(mmr.arready), 32'd1);
        @(negedge clk);
        mmr.wvalid = 1'b0; mmr.wlast = 1'b0; mmr.arvalid = 1'b0;
        m_ctrl[2] = ~old_v;
        chk("conc_ctrl2", ctrl[2], ~old_v);
        chk("conc_rvalid", 32'(mmr.rvalid), 32'd1);
        chk("conc_rdata_old", mmr.rdata, old_v);
        chk("conc_bvalid", 32'(mmr.bvalid), 32'd1);
        mmr.bready = 1'b1; mmr.rready = 1'b1;
        @(negedge clk);
        mmr.bready = 1'b0; mmr.rready = 1'b0;
        chk("conc_bvalid_drop", 32'(mmr.bvalid), 32'd0);
        chk("conc_rvalid_drop", 32'(mmr.rvalid), 32'd0);

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < SC; k++) stat[k] = $urandom;
            sel = $urandom_range(0, 3);
            if (sel < 2)       idx = $urandom_range(0, CC + 1);
            else if (sel == 2) idx = $urandom_range(30, 32 + SC + 1);
            else               idx = $urandom_range(0, 63);
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < n; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
                do_write(32'(idx * 4), 2'($urandom_range(0, 2)), n, 12'($urandom));
            end else begin
                do_read(32'(idx * 4), 2'($urandom_range(0, 2)), n, 12'($urandom), 2);
            end
        end

        // Reset in the middle of a 4-beat write
        @(negedge clk);
        mmr.awvalid = 1'b1; mmr.awid = 12'h0B0; mmr.awaddr = 32'h00;
        mmr.awlen = 4'd3; mmr.awburst = 2'b01; mmr.awsize = 3'd2;
        @(negedge clk);
        mmr.awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mmr.wvalid = 1'b1; mmr.wdata = 32'hC0DE0000 + 32'(k); mmr.wstrb = 4'hF; mmr.wlast = 1'b0;
            @(negedge clk);
        end
        mmr.wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < CC; i++) m_ctrl[i] = '0;
        chk_all_ctrl("abort");
        chk("abort_wready", 32'(mmr.wready), 32'd0);
        chk("abort_bvalid", 32'(mmr.bvalid), 32'd0);
        chk("abort_awready_in_rst", 32'(mmr.awready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_awready", 32'(mmr.awready), 32'd1);
        chk("abort_arready", 32'(mmr.arready), 32'd1);
        mmr.bready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_b", 32'(mmr.bvalid), 32'd0);
        end
        mmr.bready = 1'b0;
        wdat[0] = 32'h0BADF00D; wstb[0] = 4'hF;
        do_write(32'h1C, 2'b01, 1, 12'h0B1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mmr_reg_bank.md
MMR_REG_BANK -- requirements
Module: mmr_reg_bank_m

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, AXI3 data width; ID_W, 12, AXI3 ID width; CTRL_COUNT, 8, RW control registers; STAT_COUNT, 8, RO status registers.
REQ-002 clk  in  1  single block clock, driven from PS7 fclk0.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mmr  axi3_if.s  -  AXI3 slave; channels AW, W, B, AR, R carry full signal set incl. id, len[3:0], size, burst, wid, wstrb, last.
REQ-005 ctrl  out  CTRL_COUNT x DATA_W  control register contents.
REQ-006 ctrl_wr  out  CTRL_COUNT  one-cycle pulse per control register written.
REQ-007 stat  in  STAT_COUNT x DATA_W  status values, sampled on read.
REQ-008 stat_rd  out  STAT_COUNT  one-cycle pulse per status register read (clear-on-read support).

Function
REQ-009 Decode SHALL use word index addr[7:2]: 0..CTRL_COUNT-1 is ctrl; 32..32+STAT_COUNT-1 is stat; all other indices unmapped.
REQ-010 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE.
REQ-011 On AW handshake: capture awid, awaddr, awburst; go to W_DATA; wready=1 only in W_DATA.
REQ-012 Each W beat handshake SHALL update the addressed ctrl register per wstrb byte lanes, visible on ctrl the next cycle, with ctrl_wr pulsed in that same next cycle.
REQ-013 Address SHALL advance by 4 per beat for INCR and WRAP (WRAP treated as INCR); stay constant for FIXED.
REQ-014 A beat to stat or unmapped index SHALL not modify any register and SHALL set a sticky SLVERR flag for the burst.
REQ-015 On W handshake with wlast=1: go to W_RESP; bvalid=1 next cycle, bid=captured awid, bresp=2'b10 if sticky flag set else 2'b00.
REQ-016 On B handshake: clear sticky flag, return to W_IDLE; next AW accepted no earlier than the following cycle.
REQ-017 wid SHALL be ignored; write interleaving unsupported; wlast alone terminates the burst regardless of awlen.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-019 AR handshake in cycle N: rvalid=1 in cycle N+1 with rdata registered from the addressed location, rid=arid.
REQ-020 Beat count SHALL run 0..arlen; rlast=1 on beat arlen; after R handshake on rlast return to R_IDLE.
REQ-021 With rready held high, beats SHALL issue back-to-back, one per cycle; rvalid, rdata, rlast SHALL hold stable while rready=0.
REQ-022 Reads of unmapped index: rdata=0, rresp=2'b10; mapped: rresp=2'b00.
REQ-023 stat_rd SHALL pulse for one cycle when a stat beat's data is registered, once per beat.
REQ-024 Read and write FSMs SHALL run concurrently; a read registered in the same cycle a write lands on the same ctrl register SHALL return the pre-write value.
REQ-025 Address advance SHALL wrap within addr[7:2]; a burst crossing index 63 continues at index 0.

Reset
REQ-026 While rst=1: ctrl=0, ctrl_wr=0, stat_rd=0, awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, FSMs in W_IDLE/R_IDLE, sticky flag cleared.
REQ-027 awready and arready SHALL be 1 in the first cycle after rst falls.
REQ-028 rst asserted mid-burst SHALL abort both channels; no B or R response for the aborted transaction.

Verification
REQ-029 Single write 0x04, data 0xDEADBEEF, wstrb 4'hF -> ctrl[1]=0xDEADBEEF one cycle after W handshake, ctrl_wr=8'h02 pulse, bresp=OKAY, bid=awid.
REQ-030 Write 0x00, wstrb 4'h3, data 0x12345678 over ctrl[0]=0xAAAAAAAA -> ctrl[0]=0xAAAA5678.
REQ-031 INCR read 0x80, arlen=3, rready=1, stat[k]=k+1 -> rvalid cycles N+1..N+4, rdata 1,2,3,4, rlast on 4th beat, stat_rd pulses 1,2,4,8.
REQ-032 Write to 0x80 and read of 0x40 -> stat and ctrl unchanged, bresp=SLVERR; rdata=0, rresp=SLVERR.
REQ-033 Read burst with rready toggling 1,0,0,1 -> rdata/rlast stable while stalled, no beat lost or repeated.
REQ-034 rst pulsed during 4-beat write after 2 beats -> no bvalid, ctrl all zero, awready=1 cycle after rst falls.
